wt_mem_arbiter: RTL and testbench

// Shares one write-through memory-adapter request port between the I$ and D$ miss/write channels.

---
 rtl/wt_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter that shares one memory-adapter request port between I$ and D$,
// remembering the source of each accepted transaction so in-order returns can be steered back.
module wt_mem_arbiter #(
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   icache_req_i,
    input  logic [PayloadWidth-1:0]                icache_data_i,
    output logic                                   icache_ack_o,
    input  logic                                   dcache_req_i,
    input  logic [PayloadWidth-1:0]                dcache_data_i,
    output logic                                   dcache_ack_o,
    output logic                                   mem_req_o,
    output logic [PayloadWidth-1:0]                mem_data_o,
    output logic                                   mem_src_o,
    input  logic                                   mem_ack_i,
    input  logic                                   rtrn_vld_i,
    input  logic [RtrnWidth-1:0]                   rtrn_data_i,
    output logic                                   icache_rtrn_vld_o,
    output logic                                   dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]                   rtrn_data_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic                        gnt_q, gnt_d;      // 0 = I$, 1 = D$
    logic                        rr_q, rr_d;        // source holding priority
    logic [MaxOutstanding-1:0]   src_fifo_q, src_fifo_d;
    logic [PtrW-1:0]             wptr_q, wptr_d;
    logic [PtrW-1:0]             rptr_q, rptr_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        err_q, err_d;

    logic push, pop, fifo_empty, head_src, winner;

    // State, FIFO and counters; reset drops any request in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            rr_q       <= 1'b0;
            src_fifo_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            src_fifo_q <= src_fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Arbitration FSM, handshake outputs and source FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        src_fifo_d   = src_fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        push         = 1'b0;
        mem_req_o    = 1'b0;
        mem_src_o    = 1'b0;
        mem_data_o   = '0;
        icache_ack_o = 1'b0;
        dcache_ack_o = 1'b0;

        // Priority source wins if it asks, otherwise the other one
        if (rr_q) winner = dcache_req_i ? 1'b1 : 1'b0;
        else      winner = icache_req_i ? 1'b0 : 1'b1;

        unique case (state_q)
            IDLE: begin
                // Full check lives here only, so a grant always has a free slot
                if ((icache_req_i || dcache_req_i) && (cnt_q < CntW'(MaxOutstanding))) begin
                    gnt_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_req_o  = 1'b1;
                mem_src_o  = gnt_q;
                mem_data_o = gnt_q ? dcache_data_i : icache_data_i;
                if (mem_ack_i) begin
                    icache_ack_o = ~gnt_q;
                    dcache_ack_o = gnt_q;
                    push         = 1'b1;
                    rr_d         = ~gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_empty = (cnt_q == '0);
        head_src   = src_fifo_q[rptr_q];
        pop        = rtrn_vld_i && !fifo_empty;

        if (rtrn_vld_i && fifo_empty) err_d = 1'b1;

        if (push) begin
            src_fifo_d[wptr_q] = gnt_q;
            wptr_d             = wptr_q + PtrW'(1);
        end
        if (pop) rptr_d = rptr_q + PtrW'(1);

        if (push && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    // Return steering is combinational so the cache sees its beat in the same cycle
    always_comb begin
        icache_rtrn_vld_o = pop && !head_src;
        dcache_rtrn_vld_o = pop && head_src;
        rtrn_data_o       = rtrn_data_i;
        outstanding_o     = cnt_q;
        err_o             = err_q;
    end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Testbench for wt_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wt_mem_arbiter;

    localparam int unsigned PW   = 32;
    localparam int unsigned RW   = 16;
    localparam int unsigned MAXO = 4;
    localparam int unsigned CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          ireq, dreq, iack, dack;
    logic [PW-1:0] idata, ddata, mdata;
    logic          mreq, msrc, mack;
    logic          rvld, irv, drv;
    logic [RW-1:0] rdata_in, rdata_out;
    logic [CW-1:0] outst;
    logic          err;

    wt_mem_arbiter #(.PayloadWidth(PW), .RtrnWidth(RW), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .icache_req_i(ireq), .icache_data_i(idata), .icache_ack_o(iack),
        .dcache_req_i(dreq), .dcache_data_i(ddata), .dcache_ack_o(dack),
        .mem_req_o(mreq), .mem_data_o(mdata), .mem_src_o(msrc), .mem_ack_i(mack),
        .rtrn_vld_i(rvld), .rtrn_data_i(rdata_in),
        .icache_rtrn_vld_o(irv), .dcache_rtrn_vld_o(drv), .rtrn_data_o(rdata_out),
        .outstanding_o(outst), .err_o(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: arbiter phase, current grant, priority, in-flight source queue, sticky error
    bit m_busy, m_gnt, m_prio, m_err;
    int m_q[$];
    bit last_iack, last_dack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_gnt = 0; m_prio = 0; m_err = 0;
        m_q.delete();
    endtask

    // Check every output against the model for the current inputs, then advance one clock
    task automatic step();
        bit e_iack, e_dack, pop, e_irv, e_drv;
        logic [PW-1:0] e_data;
        int occ;
        #1;
        occ    = m_q.size();
        e_data = !m_busy ? '0 : (m_gnt ? ddata : idata);
        e_iack = m_busy && mack && !m_gnt;
        e_dack = m_busy && mack && m_gnt;
        pop    = rvld && (occ > 0);
        e_irv  = pop && (m_q[0] == 0);
        e_drv  = pop && (m_q[0] == 1);
        chk("mem_req", 64'(mreq), 64'(m_busy));
        chk("mem_src", 64'(msrc), 64'(m_busy ? m_gnt : 1'b0));
        chk("mem_data", 64'(mdata), 64'(e_data));
        chk("icache_ack", 64'(iack), 64'(e_iack));
        chk("dcache_ack", 64'(dack), 64'(e_dack));
        chk("icache_rtrn", 64'(irv), 64'(e_irv));
        chk("dcache_rtrn", 64'(drv), 64'(e_drv));
        chk("rtrn_data", 64'(rdata_out), 64'(rdata_in));
        chk("outstanding", 64'(outst), 64'(occ));
        chk("err", 64'(err), 64'(m_err));
        last_iack = e_iack;
        last_dack = e_dack;
        if (rst) begin
            m_reset();
        end else begin
            if (!m_busy) begin
                if ((ireq || dreq) && occ < int'(MAXO)) begin
                    if (m_prio) m_gnt = dreq ? 1'b1 : 1'b0;
                    else        m_gnt = ireq ? 1'b0 : 1'b1;
                    m_busy = 1;
                end
            end else if (mack) begin
                m_busy = 0;
                m_prio = !m_gnt;
            end
            if (rvld) begin
                if (occ == 0) m_err = 1;
                else void'(m_q.pop_front());
            end
            if (e_iack || e_dack) m_q.push_back(int'(m_gnt));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        ireq = 0; dreq = 0; mack = 0; rvld = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Present one request from src with an eager adapter until it is accepted
    task automatic issue(input bit src);
        bit acked = 0;
        if (src) begin dreq = 1; ddata = $urandom; end
        else     begin ireq = 1; idata = $urandom; end
        mack = 1;
        for (int k = 0; k < 10 && !acked; k++) begin
            step();
            acked = src ? last_dack : last_iack;
        end
        quiet();
        chk("issue_acked", 64'(acked), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bit exp_src;
        rst = 1; idata = 0; ddata = 0; rdata_in = 0;
        quiet();
        @(posedge clk);
        @(negedge clk);
        m_reset();
        #1;
        chk("rst_mem_req", 64'(mreq), 64'd0);
        chk("rst_outstanding", 64'(outst), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 0;

        // 1: single I$ request, adapter acks two cycles after mem_req rises
        ireq = 1; idata = 32'h1234_5678;
        step();
        #1;
        chk("t1_req_rise", 64'(mreq), 64'd1);
        chk("t1_src", 64'(msrc), 64'd0);
        step();
        step();
        mack = 1;
        #1;
        chk("t1_iack", 64'(iack), 64'd1);
        chk("t1_data", 64'(mdata), 64'h1234_5678);
        step();
        quiet();
        #1;
        chk("t1_outstanding", 64'(outst), 64'd1);
        step();

        // 2: both caches requesting continuously, adapter always ready
        do_reset();
        ireq = 1; dreq = 1; mack = 1; exp_src = 0;
        idata = $urandom; ddata = $urandom;
        for (int c = 0; c < 16; c++) begin
            rvld = (m_q.size() > 0);
            rdata_in = 16'($urandom);
            if (m_busy) begin
                #1;
                chk("t2_alternate", 64'(msrc), 64'(exp_src));
                exp_src = !exp_src;
            end
            step();
            if (last_iack) idata = $urandom;
            if (last_dack) ddata = $urandom;
        end
        quiet();

        // 3: D$ fills the source FIFO, one return frees a slot for the fifth
        do_reset();
        dreq = 1; mack = 1; acks = 0; ddata = $urandom;
        for (int c = 0; c < 30 && acks < 4; c++) begin
            step();
            if (last_dack) begin acks++; ddata = $urandom; end
        end
        chk("t3_acks", 64'(acks), 64'd4);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_held", 64'(mreq), 64'd0);
            chk("t3_full", 64'(outst), 64'd4);
            step();
        end
        rvld = 1;
        step();
        rvld = 0;
        step();
        #1;
        chk("t3_regrant", 64'(mreq), 64'd1);
        chk("t3_dack", 64'(dack), 64'd1);
        step();
        quiet();

        // 4: in-order returns steered to I$, D$, D$
        do_reset();
        issue(0); issue(1); issue(1);
        for (int k = 0; k < 3; k++) begin
            rvld = 1;
            rdata_in = 16'(10 + k);
            #1;
            chk("t4_irtrn", 64'(irv), 64'(k == 0));
            chk("t4_drtrn", 64'(drv), 64'(k != 0));
            chk("t4_data", 64'(rdata_out), 64'(10 + k));
            step();
        end
        rvld = 0;

        // 5: push and pop in one cycle, then a return with nothing outstanding
        do_reset();
        issue(0); issue(1);
        ireq = 1; idata = $urandom;
        step();
        mack = 1; rvld = 1; rdata_in = 16'h00BE;
        step();
        quiet();
        #1;
        chk("t5_same_count", 64'(outst), 64'd2);
        rvld = 1;
        step();
        step();
        #1;
        chk("t5_drained", 64'(outst), 64'd0);
        chk("t5_no_err_yet", 64'(err), 64'd0);
        step();
        rvld = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t5_err_sticky", 64'(err), 64'd1);
            step();
        end

        // 6: reset in GRANT with three outstanding
        do_reset();
        issue(0); issue(1); issue(0);
        dreq = 1; ddata = $urandom;
        step();
        #1;
        chk("t6_in_grant", 64'(mreq), 64'd1);
        chk("t6_three", 64'(outst), 64'd3);
        rst = 1;
        step();
        rst = 0; ireq = 1; dreq = 1; mack = 0;
        #1;
        chk("t6_req_low", 64'(mreq), 64'd0);
        chk("t6_out_zero", 64'(outst), 64'd0);
        chk("t6_err_zero", 64'(err), 64'd0);
        step();
        #1;
        chk("t6_icache_wins", 64'(msrc), 64'd0);
        step();
        quiet();

        // Random traffic with protocol-respecting requesters
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (last_iack || !ireq) begin ireq = ($urandom % 3) != 0; idata = $urandom; end
            if (last_dack || !dreq) begin dreq = ($urandom % 3) != 0; ddata = $urandom; end
            mack = ($urandom % 2) == 1;
            rvld = (m_q.size() > 0) ? (($urandom % 3) == 0) : (($urandom % 97) == 0);
            rdata_in = 16'($urandom);
            rst = ($urandom % 150) == 0;
            step();
        end
        rst = 0;
        quiet();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
